// File: rtl/sqrt2_seq_if.sv
// ---------------------------------------------------------------------------
// sqrt2_seq_if
//   Stream bundle between the sqrt2 sequencer and its producer/consumer.
//
//   Operand stream (producer -> sequencer):
//     in_valid   operand valid
//     in_ready   sequencer can take an operand this cycle
//     in_data    FP16 operand
//   Result stream (sequencer -> consumer):
//     out_valid  result FIFO non-empty
//     out_ready  consumer pops the head entry
//     out_data   FP16 result at the FIFO head (0 when empty)
//     out_flags  {timeout_err, nan, pinf} at the FIFO head (0 when empty)
//
//   master: the environment side (drives operands, consumes results)
//   slave : the sequencer side
// ---------------------------------------------------------------------------
interface sqrt2_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_flags;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_flags
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_flags
  );
endinterface

// File: rtl/sqrt2_seq.sv
// ---------------------------------------------------------------------------
// sqrt2_seq
//   Wraps the sqrt2 half-precision square-root core with valid/ready streams.
//   One operand is in flight at a time. For each accepted operand the
//   sequencer drives the shared tri-state bus for a single LOAD cycle, holds
//   ENABLE while waiting for RESULT (bounded by TIMEOUT), captures the result
//   and flags into a small output FIFO, then drops ENABLE for one GAP cycle
//   so the core clears itself and releases the bus.
//
//   Parameters
//     DEPTH    output FIFO entries (power of two, >= 2)
//     TIMEOUT  last WAIT counter value before the operation is aborted
//
//   Ports
//     clk           rising-edge clock, shared with the core
//     rst           asynchronous, active-high reset
//     s             stream bundle (slave view), see sqrt2_seq_if
//     sq_data_io    shared 16-bit bus to the core's IO_DATA
//     sq_enable_o   core ENABLE, registered
//     sq_result_i   core RESULT
//     sq_is_nan_i   core NaN flag
//     sq_is_pinf_i  core +Inf flag
// ---------------------------------------------------------------------------
module sqrt2_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  sqrt2_seq_if.slave  s,
  inout  wire  [15:0] sq_data_io,
  output logic        sq_enable_o,
  input  logic        sq_result_i,
  input  logic        sq_is_nan_i,
  input  logic        sq_is_pinf_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C    = TW'(TIMEOUT);
  localparam logic [15:0]   TIMEOUT_DATA = 16'h7E00;  // quiet NaN reported on abort

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_GAP
  } state_t;

  // FSM state and registered outputs
  state_t          state_q;
  logic            sq_enable_q;
  logic [15:0]     operand_q;
  logic [TW-1:0]   wait_cnt_q;

  // Output FIFO: entry = {timeout_err, nan, pinf, data[15:0]}
  logic [18:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            in_ready;
  logic            accept;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [18:0]     push_entry;
  logic [18:0]     head_entry;

  // -------------------------------------------------------------------------
  // Handshake / capture decisions
  // -------------------------------------------------------------------------
  // Admitting an operand only while a FIFO slot is free means the capture
  // at the end of the operation can never find the FIFO full.
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (state_q == ST_IDLE) && (count_q < DEPTH_C);
  assign accept     = in_ready && s.in_valid;
  assign pop        = !fifo_empty && s.out_ready;

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (state_q == ST_WAIT) begin
      if (sq_result_i) begin
        // The core owns the bus in WAIT; its result is valid with RESULT.
        push       = 1'b1;
        push_entry = {1'b0, sq_is_nan_i, sq_is_pinf_i, sq_data_io};
      end else if (wait_cnt_q == TIMEOUT_C) begin
        push       = 1'b1;
        push_entry = {1'b1, 2'b00, TIMEOUT_DATA};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  // sq_enable_q is cleared by the asynchronous reset, which also resets the
  // core immediately; nothing from an interrupted operation is pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sq_enable_q <= 1'b0;
      operand_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            operand_q   <= s.in_data;
            sq_enable_q <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // The core parses the bus at the edge closing this cycle.
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (push) begin
            sq_enable_q <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= ST_GAP;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end
        ST_GAP: begin
          // ENABLE low for this cycle clears the core and frees the bus.
          state_q <= ST_IDLE;
        end
        default: begin
          sq_enable_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign sq_enable_o = sq_enable_q;

  // Only LOAD drives the bus. The core starts driving one cycle after LOAD
  // ends, so a full high-Z cycle always separates the two drivers.
  assign sq_data_io = (state_q == ST_LOAD) ? operand_q : 16'hzzzz;

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head_entry = fifo_empty ? 19'd0 : mem_q[rd_ptr_q];

  assign s.in_ready  = in_ready;
  assign s.out_valid = !fifo_empty;
  assign s.out_data  = head_entry[15:0];
  assign s.out_flags = head_entry[18:16];

  // A capture must always land in a free slot.
  assert property (@(posedge clk) disable iff (rst) push |-> (count_q < DEPTH_C));

endmodule

// File: tb/tb_sqrt2_seq.sv
// ---------------------------------------------------------------------------
// tb_sqrt2_seq
//   Bench for the sqrt2 sequencer. A behavioural model of the sqrt2 core
//   (parse on first enabled edge, bus drive from the second, RESULT after a
//   fixed latency, cleared by ENABLE low) sits on the shared bus. Expected
//   results come from a real-arithmetic FP16 square root.
// ---------------------------------------------------------------------------
module tb_sqrt2_seq;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt2_seq_if bus_if ();
  wire  [15:0] sq_bus;
  logic        sq_enable;
  logic        sq_result;
  logic        sq_is_nan;
  logic        sq_is_pinf;

  sqrt2_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (bus_if),
    .sq_data_io   (sq_bus),
    .sq_enable_o  (sq_enable),
    .sq_result_i  (sq_result),
    .sq_is_nan_i  (sq_is_nan),
    .sq_is_pinf_i (sq_is_pinf)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int edge_cnt  = 0;
  bit stub_mode = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- FP16 reference arithmetic ----------------
  function automatic real fp16_to_real(input logic [15:0] h);
    real r;
    int  e;
    int  m;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 0) begin
      r = real'(m);
      e = 1;
    end else begin
      r = real'(m) + 1024.0;
    end
    for (int i = 0; i < 25 - e; i++) r = r / 2.0;
    for (int i = 0; i < e - 25; i++) r = r * 2.0;
    return r;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real v_in);
    real v;
    real m;
    real frac;
    int  e;
    int  mi;
    logic [4:0] ef;
    logic [9:0] mf;
    v = v_in;
    e = 0;
    if (v <= 0.0) return 16'h0000;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m    = v * 1024.0;
    mi   = $rtoi(m);
    frac = m - real'(mi);
    if (frac > 0.5 || (frac == 0.5 && mi[0])) mi++;
    if (mi == 2048) begin mi = 1024; e++; end
    ef = 5'(e + 15);
    mf = 10'(mi - 1024);
    return {1'b0, ef, mf};
  endfunction

  function automatic bit is_special(input logic [15:0] h);
    return ((h[14:10] == 5'h1F) && (h[9:0] != 10'd0)) || (h == 16'h7C00) || (h == 16'h8000);
  endfunction

  // {nan, pinf, data}
  function automatic logic [17:0] ref_sqrt(input logic [15:0] h);
    if ((h[14:10] == 5'h1F) && (h[9:0] != 10'd0)) return {2'b10, h | 16'h0200};
    if (h == 16'h7C00) return {2'b01, 16'h7C00};
    if (h == 16'h8000 || h == 16'h0000) return {2'b00, h};
    if (h[15]) return {2'b10, 16'hFE00};
    return {2'b00, real_to_fp16($sqrt(fp16_to_real(h)))};
  endfunction

  // ---------------- sqrt2 core model ----------------
  logic [4:0]  core_cnt     = '0;
  logic [17:0] core_res     = '0;
  bit          core_special = 1'b0;

  always @(posedge clk or negedge sq_enable) begin
    if (!sq_enable) begin
      core_cnt <= '0;
    end else begin
      if (core_cnt == 5'd0) begin
        core_res     <= ref_sqrt(sq_bus);
        core_special <= is_special(sq_bus);
      end
      if (core_cnt != 5'd31) core_cnt <= core_cnt + 5'd1;
    end
  end

  assign sq_result  = sq_enable && !stub_mode && (core_cnt >= (core_special ? 5'd2 : 5'd12));
  assign sq_is_nan  = sq_result && core_res[17];
  assign sq_is_pinf = sq_result && core_res[16];
  assign sq_bus     = (sq_enable && core_cnt >= 5'd2) ? core_res[15:0] : 16'hzzzz;

  // ---------------- helpers ----------------
  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] op, output int acc);
    int n;
    n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = op;
    while (!bus_if.in_ready && n < 400) begin tick(); n++; end
    chk(bus_if.in_ready == 1'b1, "accept_wait", int'(bus_if.in_ready), 1);
    tick();
    acc = edge_cnt;
    bus_if.in_valid = 1'b0;
    chk(sq_bus == op, "load_bus", int'(sq_bus), int'(op));
    $display("send op=%h edge=%0d", op, acc);
  endtask

  task automatic wait_out(output int seen);
    int n;
    n = 0;
    while (!bus_if.out_valid && n < 100) begin tick(); n++; end
    chk(bus_if.out_valid == 1'b1, "out_valid_wait", int'(bus_if.out_valid), 1);
    seen = edge_cnt;
  endtask

  task automatic pop_expect(input logic [15:0] d, input logic [2:0] f, input string name);
    $display("pop %s data=%h flags=%b valid=%0b", name, bus_if.out_data, bus_if.out_flags, bus_if.out_valid);
    chk(bus_if.out_valid == 1'b1, {name, "_valid"}, int'(bus_if.out_valid), 1);
    chk(bus_if.out_data == d, {name, "_data"}, int'(bus_if.out_data), int'(d));
    chk(bus_if.out_flags == f, {name, "_flags"}, int'(bus_if.out_flags), int'(f));
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] op;
    logic [15:0] data;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  initial begin
    vec_t        vecs [7];
    logic [15:0] full_ops [5];
    logic [15:0] specials [4];
    logic [17:0] r;
    int          acc, prev, seen, e, hits;

    vecs[0] = '{16'h4400, 16'h4000, 3'b000, 13};
    vecs[1] = '{16'h7C00, 16'h7C00, 3'b001, 3};
    vecs[2] = '{16'h8000, 16'h8000, 3'b000, 3};
    vecs[3] = '{16'h7E01, 16'h7E01, 3'b010, 3};
    vecs[4] = '{16'hC400, 16'hFE00, 3'b010, 13};
    vecs[5] = '{16'h3C00, 16'h3C00, 3'b000, 13};
    vecs[6] = '{16'h0001, 16'h0C00, 3'b000, 13};
    full_ops = '{16'h4400, 16'h3C00, 16'h4C00, 16'h5400, 16'h5C00};
    specials = '{16'h7C00, 16'h8000, 16'h7E01, 16'hFD55};

    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) tick();
    chk(sq_enable == 1'b0, "rst_enable", int'(sq_enable), 0);
    chk(bus_if.out_valid == 1'b0, "rst_out_valid", int'(bus_if.out_valid), 0);
    chk(bus_if.out_data == 16'h0, "rst_out_data", int'(bus_if.out_data), 0);
    chk(bus_if.out_flags == 3'b0, "rst_out_flags", int'(bus_if.out_flags), 0);
    #2 rst = 1'b0;
    tick();
    chk(bus_if.in_ready == 1'b1, "ready_after_rst", int'(bus_if.in_ready), 1);

    // ---- table vectors, one at a time ----
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].op, acc);
      chk(sq_enable == 1'b1, "load_enable", int'(sq_enable), 1);
      wait_out(seen);
      chk(seen - acc == vecs[i].lat, "latency", seen - acc, vecs[i].lat);
      pop_expect(vecs[i].data, vecs[i].flags, "vec");
      chk(bus_if.out_valid == 1'b0, "empty_after_pop", int'(bus_if.out_valid), 0);
    end

    // ---- back-to-back special operands ----
    send(16'h7C00, acc);
    prev = acc;
    send(16'h8000, acc);
    chk(acc - prev == 5, "special_spacing", acc - prev, 5);
    prev = acc;
    send(16'h7E01, acc);
    chk(acc - prev == 5, "special_spacing", acc - prev, 5);
    repeat (4) tick();
    pop_expect(16'h7C00, 3'b001, "b2b0");
    pop_expect(16'h8000, 3'b000, "b2b1");
    pop_expect(16'h7E01, 3'b010, "b2b2");

    // ---- FIFO full, single pop admits next, order across wrap ----
    send(full_ops[0], acc);
    prev = acc;
    for (int i = 1; i < DEPTH; i++) begin
      send(full_ops[i], acc);
      chk(acc - prev == 15, "normal_spacing", acc - prev, 15);
      prev = acc;
    end
    repeat (16) tick();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = full_ops[4];
    hits = 0;
    repeat (10) begin
      if (bus_if.in_ready) hits++;
      tick();
    end
    chk(hits == 0, "full_holds_ready", hits, 0);
    r = ref_sqrt(full_ops[0]);
    chk(bus_if.out_data == r[15:0], "full_head", int'(bus_if.out_data), int'(r[15:0]));
    bus_if.out_ready = 1'b1;
    tick();
    e = edge_cnt;
    bus_if.out_ready = 1'b0;
    chk(bus_if.in_ready == 1'b1, "ready_after_pop", int'(bus_if.in_ready), 1);
    tick();
    bus_if.in_valid = 1'b0;
    chk(edge_cnt == e + 1 && sq_bus == full_ops[4], "accept_after_pop", int'(sq_bus), int'(full_ops[4]));
    repeat (16) tick();
    for (int i = 1; i < 5; i++) begin
      r = ref_sqrt(full_ops[i]);
      pop_expect(r[15:0], {1'b0, r[17:16]}, "wrap");
    end

    // ---- timeout with a core that never answers ----
    stub_mode = 1'b1;
    send(16'h4400, acc);
    wait_out(seen);
    chk(seen - acc == TIMEOUT + 2, "timeout_latency", seen - acc, TIMEOUT + 2);
    chk(sq_enable == 1'b0, "gap_enable", int'(sq_enable), 0);
    chk(bus_if.in_ready == 1'b0, "gap_not_ready", int'(bus_if.in_ready), 0);
    tick();
    chk(bus_if.in_ready == 1'b1, "idle_after_gap", int'(bus_if.in_ready), 1);
    chk(sq_enable == 1'b0, "idle_enable", int'(sq_enable), 0);
    pop_expect(16'h7E00, 3'b100, "timeout");
    stub_mode = 1'b0;

    // ---- reset during WAIT ----
    send(16'h7C00, acc);
    repeat (4) tick();
    chk(bus_if.out_valid == 1'b1, "pre_rst_valid", int'(bus_if.out_valid), 1);
    send(16'h4400, acc);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk(sq_enable == 1'b0, "rst_async_enable", int'(sq_enable), 0);
    chk(bus_if.out_valid == 1'b0, "rst_fifo_empty", int'(bus_if.out_valid), 0);
    chk(bus_if.out_data == 16'h0, "rst_data_zero", int'(bus_if.out_data), 0);
    tick();
    tick();
    #2 rst = 1'b0;
    send(16'h3C00, acc);
    wait_out(seen);
    chk(seen - acc == 13, "post_rst_latency", seen - acc, 13);
    pop_expect(16'h3C00, 3'b000, "post_rst");

    // ---- randomized stream with random back-pressure ----
    begin
      logic [18:0] exp_q [$];
      int          got;
      int          n_ops;
      got   = 0;
      n_ops = 60;
      fork
        begin
          logic [15:0] op;
          logic [17:0] rr;
          int          a;
          for (int i = 0; i < n_ops; i++) begin
            if ($urandom_range(0, 3) == 0) op = specials[$urandom_range(0, 3)];
            else op = 16'($urandom);
            rr = ref_sqrt(op);
            exp_q.push_back({1'b0, rr});
            send(op, a);
          end
        end
        begin
          logic [18:0] ex;
          int          cyc;
          cyc = 0;
          while (got < n_ops && cyc < 20000) begin
            tick();
            bus_if.out_ready = 1'($urandom_range(0, 1));
            if (bus_if.out_valid && bus_if.out_ready) begin
              if (exp_q.size() == 0) begin
                chk(1'b0, "rand_unexpected", int'(bus_if.out_data), 0);
              end else begin
                ex = exp_q.pop_front();
                $display("rand pop data=%h flags=%b exp=%h", bus_if.out_data, bus_if.out_flags, ex);
                chk({bus_if.out_flags, bus_if.out_data} == ex, "rand_entry",
                    int'({bus_if.out_flags, bus_if.out_data}), int'(ex));
              end
              got++;
            end
            cyc++;
          end
          bus_if.out_ready = 1'b0;
          chk(got == n_ops, "rand_count", got, n_ops);
        end
      join
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
